// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline back end.
//   XLEN / NREG / REG_AW : register width, count and index width
//   CNT_W                : default width of the write-activity counter
//   WB_SEL_ALU/WB_SEL_MEM: encodings of the mem_to_reg write-back select
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register-file read port.
// x0 reads as zero. A write being committed to the addressed register in
// the same cycle is bypassed through.
// Optional macro REGFILE_READ_GATE_EN adds a hold register. While en is low
// the port output is frozen at the last value seen with en high.
// Ports:
//   clk, reset  clock / synchronous active-high reset (used by the hold register)
//   addr, en    read index and port-active strobe
//   regs        flat view of the register array
//   wr_addr     destination index of the write in flight
//   wr_commit   write in flight is committed this cycle
//   wr_data     data of the write in flight
//   data        read result
module regfile_rd_port
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREG   = riscv_pkg::NREG,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_AW-1:0]         addr,
    input  logic                      en,
    input  logic [NREG-1:0][XLEN-1:0] regs,
    input  logic [REG_AW-1:0]         wr_addr,
    input  logic                      wr_commit,
    input  logic [XLEN-1:0]           wr_data,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0] live;

    // wr_commit already excludes reset, so the bypass is suppressed there.
    always_comb begin
        live = regs[addr];
        if (addr == '0) begin
            live = '0;
        end else if (wr_commit && (wr_addr == addr)) begin
            live = wr_data;
        end
    end

`ifdef REGFILE_READ_GATE_EN
    logic [XLEN-1:0] hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (en) begin
            hold <= live;
        end
    end

    always_comb begin
        data = en ? live : hold;
    end
`else
    logic unused_gate_inputs;
    assign unused_gate_inputs = &{1'b0, clk, reset, en};

    always_comb begin
        data = live;
    end
`endif

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file.
// Selects load data or ALU result from MEM/WB and commits it to x1..x31.
// It also serves two bypassed ID-stage read ports and counts committed writes,
// saturating at all-ones.
// Optional macro REGFILE_READ_GATE_EN: the read ports hold their output while
// rsN_en is low.
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   mem_data_in, alu_result_in write-back candidates from MEM/WB
//   rd_in, reg_write_in        destination index and write enable
//   mem_to_reg_in              1 selects load data, 0 selects ALU result
//   rs1_addr/rs2_addr          read indices
//   rs1_en/rs2_en              read port active strobes
//   rs1_data/rs2_data          read data
//   wb_data                    selected write-back value (comb)
//   wb_commit                  write actually committed this cycle (comb)
//   wr_count                   saturating count of committed writes
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREG   = riscv_pkg::NREG,
    parameter int REG_AW = riscv_pkg::REG_AW,
    parameter int CNT_W  = riscv_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   mem_data_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              rs1_en,
    input  logic              rs2_en,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  wr_count
);

    logic [NREG-1:0][XLEN-1:0] regs;

    always_comb begin
        wb_data = (mem_to_reg_in == WB_SEL_MEM) ? mem_data_in : alu_result_in;
    end

    always_comb begin
        wb_commit = reg_write_in && (rd_in != '0) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (wb_commit) begin
            regs[rd_in] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (wb_commit && (wr_count != '1)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    regfile_rd_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_rd_port1 (
        .clk       (clk),
        .reset     (reset),
        .addr      (rs1_addr),
        .en        (rs1_en),
        .regs      (regs),
        .wr_addr   (rd_in),
        .wr_commit (wb_commit),
        .wr_data   (wb_data),
        .data      (rs1_data)
    );

    regfile_rd_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_rd_port2 (
        .clk       (clk),
        .reset     (reset),
        .addr      (rs2_addr),
        .en        (rs2_en),
        .regs      (regs),
        .wr_addr   (rd_in),
        .wr_commit (wb_commit),
        .wr_data   (wb_data),
        .data      (rs2_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_commit;
    logic [31:0] wr_count;

    // second instance with a narrow counter to reach saturation quickly
    logic [31:0] s_rs1_data;
    logic [31:0] s_rs2_data;
    logic [31:0] s_wb_data;
    logic        s_wb_commit;
    logic [3:0]  s_wr_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .mem_data_in   (mem_data_in),
        .alu_result_in (alu_result_in),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_en        (rs1_en),
        .rs2_en        (rs2_en),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_data       (wb_data),
        .wb_commit     (wb_commit),
        .wr_count      (wr_count)
    );

    wb_regfile #(.CNT_W(4)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .mem_data_in   (mem_data_in),
        .alu_result_in (alu_result_in),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_en        (rs1_en),
        .rs2_en        (rs2_en),
        .rs1_data      (s_rs1_data),
        .rs2_data      (s_rs2_data),
        .wb_data       (s_wb_data),
        .wb_commit     (s_wb_commit),
        .wr_count      (s_wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                            input logic m2r, input logic we);
        rd_in         = rd;
        alu_result_in = alu;
        mem_data_in   = mem;
        mem_to_reg_in = m2r;
        reg_write_in  = we;
    endtask

    logic [31:0] m [32];
    logic [31:0] mcnt;
    logic [3:0]  scnt;
    logic [31:0] e_wb, e_r1, e_r2;
    logic        e_c;

    initial begin
        reset = 1'b1;
        rs1_addr = '0; rs2_addr = '0; rs1_en = 1'b1; rs2_en = 1'b1;
        drive_wr(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 1. reset for two clocks, then all reads are zero; a write during reset does not commit
        step();
        step();
        drive_wr(5'd3, 32'h0000_AAAA, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check("reset_rs1", rs1_data, 32'h0);
            check("reset_rs2", rs2_data, 32'h0);
        end
        check("reset_commit", {31'b0, wb_commit}, 32'h0);
        check("reset_count", wr_count, 32'h0);
        step();
        reset = 1'b0;

        // 2. ALU write to x5
        drive_wr(5'd5, 32'h1234_5678, 32'h0BAD_0BAD, 1'b0, 1'b1);
        #1;
        check("alu_wb_data", wb_data, 32'h1234_5678);
        check("alu_commit", {31'b0, wb_commit}, 32'h1);
        step();
        reg_write_in = 1'b0;
        rs1_addr = 5'd5;
        #1;
        check("x5_read", rs1_data, 32'h1234_5678);
        check("count_1", wr_count, 32'd1);

        // 3. load write to x7 with same-cycle bypass on both ports
        drive_wr(5'd7, 32'h5555_5555, 32'hDEAD_BEEF, 1'b1, 1'b1);
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        check("bypass_rs1", rs1_data, 32'hDEAD_BEEF);
        check("bypass_rs2", rs2_data, 32'hDEAD_BEEF);
        step();
        reg_write_in = 1'b0;
        rs2_addr = 5'd5;
        #1;
        check("x7_stored", rs1_data, 32'hDEAD_BEEF);
        check("x5_kept", rs2_data, 32'h1234_5678);
        check("count_2", wr_count, 32'd2);

        // 4. write to x0 is dropped
        drive_wr(5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        rs1_addr = 5'd0;
        #1;
        check("x0_commit", {31'b0, wb_commit}, 32'h0);
        check("x0_bypass", rs1_data, 32'h0);
        step();
        reg_write_in = 1'b0;
        #1;
        check("x0_read", rs1_data, 32'h0);
        check("x0_count", wr_count, 32'd2);

        // 5. write x3 normally, then reset together with another write to x3
        drive_wr(5'd3, 32'h0000_0055, 32'h0, 1'b0, 1'b1);
        step();
        drive_wr(5'd3, 32'h0000_AAAA, 32'h0, 1'b0, 1'b1);
        reset = 1'b1;
        rs1_addr = 5'd3;
        #1;
        check("rst_no_bypass", rs1_data, 32'h0000_0055);
        check("rst_no_commit", {31'b0, wb_commit}, 32'h0);
        check("count_3", wr_count, 32'd3);
        step();
        reset = 1'b0;
        reg_write_in = 1'b0;
        rs2_addr = 5'd5;
        #1;
        check("rst_x3", rs1_data, 32'h0);
        check("rst_x5", rs2_data, 32'h0);
        check("rst_count", wr_count, 32'h0);
        check("rst_scount", 32'(s_wr_count), 32'h0);

        // 6. read gating: x9 = 0x11 seen with en=1, then overwritten with en=0
        drive_wr(5'd9, 32'h0000_0011, 32'h0, 1'b0, 1'b1);
        rs1_addr = 5'd9;
        rs2_addr = 5'd9;
        rs1_en = 1'b1;
        step();
        drive_wr(5'd9, 32'h0000_0022, 32'h0, 1'b0, 1'b1);
        rs1_en = 1'b0;
        #1;
`ifdef REGFILE_READ_GATE_EN
        check("gate_hold_wr", rs1_data, 32'h0000_0011);
`else
        check("gate_hold_wr", rs1_data, 32'h0000_0022);
`endif
        check("gate_rs2_live", rs2_data, 32'h0000_0022);
        step();
        reg_write_in = 1'b0;
        #1;
`ifdef REGFILE_READ_GATE_EN
        check("gate_hold", rs1_data, 32'h0000_0011);
`else
        check("gate_hold", rs1_data, 32'h0000_0022);
`endif
        rs1_en = 1'b1;
        #1;
        check("gate_release", rs1_data, 32'h0000_0022);
        check("gate_count", wr_count, 32'd2);

        // random traffic against a reference model
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = '0;
        mcnt = '0;
        scnt = '0;
        for (int n = 0; n < 10000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive_wr(5'($urandom_range(0, 31)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_in : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rd_in : 5'($urandom_range(0, 31));
            #1;
            e_wb = mem_to_reg_in ? mem_data_in : alu_result_in;
            e_c  = reg_write_in && (rd_in != 5'd0) && !reset;
            e_r1 = (rs1_addr == 5'd0) ? 32'h0 : (e_c && rd_in == rs1_addr) ? e_wb : m[rs1_addr];
            e_r2 = (rs2_addr == 5'd0) ? 32'h0 : (e_c && rd_in == rs2_addr) ? e_wb : m[rs2_addr];
            check("rnd_wb_data", wb_data, e_wb);
            check("rnd_commit", {31'b0, wb_commit}, {31'b0, e_c});
            check("rnd_rs1", rs1_data, e_r1);
            check("rnd_rs2", rs2_data, e_r2);
            check("rnd_count", wr_count, mcnt);
            check("rnd_scount", 32'(s_wr_count), 32'(scnt));
            check("rnd_s_rs1", s_rs1_data, e_r1);
            step();
            if (reset) begin
                for (int i = 0; i < 32; i++) m[i] = '0;
                mcnt = '0;
                scnt = '0;
            end else if (e_c) begin
                m[rd_in] = e_wb;
                mcnt++;
                if (scnt != 4'hF) scnt++;
            end
        end

        // counter saturation on the narrow instance
        reset = 1'b0;
        drive_wr(5'd1, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step();
        mcnt += 20;
        check("sat_scount", 32'(s_wr_count), 32'h0000_000F);
        check("sat_count", wr_count, mcnt);
        step();
        reg_write_in = 1'b0;
        #1;
        check("sat_hold", 32'(s_wr_count), 32'h0000_000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
